// File: rtl/seq_det_pkg.sv
// Shared encodings and defaults for the serial sequence detector controller.
package seq_det_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] DEF_PATTERN = 4'b1101;
    localparam int         DEF_LEN     = 4;

    // Legal pattern lengths are 2..max_len; anything else is pulled to the nearest bound.
    function automatic int clamp_len(input int len, input int max_len);
        if (len < 2)
            return 2;
        if (len > max_len)
            return max_len;
        return len;
    endfunction

endpackage

// File: rtl/seq_det_if.sv
// Configuration handshake between host (master) and detector controller (slave).
interface seq_det_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    localparam int LEN_W = $clog2(PAT_W) + 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_target;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        output cfg_ready
    );

endinterface

// File: rtl/seq_match.sv
// History shift register, bits_seen counter and length-masked comparator (Mealy match).
module seq_match #(
    parameter int PAT_W = 4,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             shift,
    input  logic             in,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             overlap,
    output logic             match
);

    logic [PAT_W-2:0] hist;
    logic [LEN_W-1:0] bits_seen;
    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] mask;

    assign window = {hist, in};

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++)
            mask[i] = (LEN_W'(i) < len);
    end

    // The incoming bit completes the window, so only len-1 prior bits are required.
    assign match = (((window ^ pattern) & mask) == '0) && (bits_seen >= len - LEN_W'(1));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            hist      <= '0;
            bits_seen <= '0;
        end else if (shift) begin
            if (match && !overlap) begin
                hist      <= '0;
                bits_seen <= '0;
            end else begin
                hist <= window[PAT_W-2:0];
                if (bits_seen != LEN_W'(PAT_W))
                    bits_seen <= bits_seen + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller around a programmable Mealy sequence detector.
// Optional build macro SEQDET_IRQ_EN adds a sticky completion interrupt (irq / irq_clr).
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    seq_det_if.slave         cfg,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic             in,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_count
`ifdef SEQDET_IRQ_EN
   ,output logic             irq,
    input  logic             irq_clr
`endif
);

    localparam int LEN_W = $clog2(PAT_W) + 1;

    logic [1:0]       state;
    logic [PAT_W-1:0] pat_r;
    logic [LEN_W-1:0] len_r;
    logic             ovl_r;
    logic [CNT_W-1:0] tgt_r;

    logic cfg_acc;
    logic run_go;
    logic shift;
    logic match;
    logic hit;
    logic final_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign cfg.cfg_ready = (state != ST_RUN);
    assign cfg_acc       = cfg.cfg_valid & cfg.cfg_ready;
    assign run_go        = (state != ST_RUN) & start & ~abort;
    assign shift         = (state == ST_RUN) & in_valid;
    assign hit           = shift & match & ~abort;
    assign final_hit     = hit & (tgt_r != '0) & (hit_count + CNT_W'(1) == tgt_r);

    assign out  = hit;
    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    seq_match #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_match (
        .clk     (clk),
        .reset   (reset),
        .clr     (run_go),
        .shift   (shift),
        .in      (in),
        .pattern (pat_r),
        .len     (len_r),
        .overlap (ovl_r),
        .match   (match)
    );

    // Config captured alongside a start is already in effect for that run's first bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            pat_r     <= PAT_W'(DEF_PATTERN);
            len_r     <= LEN_W'(clamp_len(DEF_LEN, PAT_W));
            ovl_r     <= 1'b0;
            tgt_r     <= '0;
            hit_count <= '0;
        end else begin
            if (cfg_acc) begin
                pat_r <= cfg.cfg_pattern;
                len_r <= LEN_W'(clamp_len(int'(cfg.cfg_len), PAT_W));
                ovl_r <= cfg.cfg_overlap;
                tgt_r <= cfg.cfg_target;
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (start) begin
                        state     <= ST_RUN;
                        hit_count <= '0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (hit) begin
                        hit_count <= sat_inc(hit_count);
                        if (final_hit)
                            state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SEQDET_IRQ_EN
    // A set on DONE entry outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset)
            irq <= 1'b0;
        else if (final_hit)
            irq <= 1'b1;
        else if (irq_clr)
            irq <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed, table-driven bench for seq_det_ctrl (PAT_W=4, CNT_W=8), with extra irq checks when SEQDET_IRQ_EN is defined.
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       in_valid;
    logic       din;
    logic       out;
    logic       busy;
    logic       done;
    logic [7:0] hit_count;
`ifdef SEQDET_IRQ_EN
    logic       irq;
    logic       irq_clr;
`endif

    seq_det_if #(.PAT_W(4), .CNT_W(8)) cfg_bus ();

    seq_det_ctrl #(.PAT_W(4), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg       (cfg_bus),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in        (din),
        .out       (out),
        .busy      (busy),
        .done      (done),
        .hit_count (hit_count)
`ifdef SEQDET_IRQ_EN
       ,.irq       (irq),
        .irq_clr   (irq_clr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         cv;
        logic [3:0] pat;
        logic [2:0] len;
        bit         ovl;
        logic [7:0] tgt;
        bit         st;
        bit         ab;
        bit         iv;
        bit         di;
        bit         chk;
        bit         eo;
        bit         eb;
        bit         ed;
        bit         er;
        logic [7:0] ec;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic row(input bit rst, input bit cv, input logic [3:0] pat, input logic [2:0] len,
                       input bit ovl, input logic [7:0] tgt, input bit st, input bit ab, input bit iv,
                       input bit di, input bit chk, input bit eo, input bit eb, input bit ed,
                       input bit er, input logic [7:0] ec);
        vec_t v;
        v.rst = rst; v.cv = cv; v.pat = pat; v.len = len; v.ovl = ovl; v.tgt = tgt;
        v.st = st; v.ab = ab; v.iv = iv; v.di = di; v.chk = chk;
        v.eo = eo; v.eb = eb; v.ed = ed; v.er = er; v.ec = ec;
        vecs.push_back(v);
    endtask

    // One serial bit while RUN is expected.
    task automatic bitr(input bit iv, input bit di, input bit eo, input logic [7:0] ec);
        row(0, 0, 4'h0, 3'd0, 0, 8'd0, 0, 0, iv, di, 1, eo, 1, 0, 0, ec);
    endtask

    task automatic idle_row(input bit ed, input logic [7:0] ec);
        row(0, 0, 4'h0, 3'd0, 0, 8'd0, 0, 0, 0, 0, 1, 0, 0, ed, 1, ec);
    endtask

    task automatic start_row(input bit cv, input logic [3:0] pat, input logic [2:0] len, input bit ovl,
                             input logic [7:0] tgt, input bit ed, input logic [7:0] ec);
        row(0, cv, pat, len, ovl, tgt, 1, 0, 0, 0, 1, 0, 0, ed, 1, ec);
    endtask

    task automatic abort_row(input bit iv, input bit di, input logic [7:0] ec);
        row(0, 0, 4'h0, 3'd0, 0, 8'd0, 0, 1, iv, di, 1, 0, 1, 0, 0, ec);
    endtask

    task automatic done_bit(input bit di);
        row(0, 0, 4'h0, 3'd0, 0, 8'd0, 0, 0, 1, di, 1, 0, 0, 1, 1, 8'd3);
    endtask

    task automatic drive(input vec_t v);
        reset               = v.rst;
        cfg_bus.cfg_valid   = v.cv;
        cfg_bus.cfg_pattern = v.pat;
        cfg_bus.cfg_len     = v.len;
        cfg_bus.cfg_overlap = v.ovl;
        cfg_bus.cfg_target  = v.tgt;
        start               = v.st;
        abort               = v.ab;
        in_valid            = v.iv;
        din                 = v.di;
    endtask

    task automatic build_table();
        // reset, then default config: 11011101 -> hits on bits 4 and 8
        row(1, 0, 4'h0, 3'd0, 0, 8'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
        idle_row(0, 0);
        start_row(0, 4'h0, 3'd0, 0, 8'd0, 0, 0);
        bitr(1, 1, 0, 0); bitr(1, 1, 0, 0); bitr(1, 0, 0, 0); bitr(1, 1, 1, 0);
        bitr(1, 1, 0, 1); bitr(1, 1, 0, 1); bitr(1, 0, 0, 1); bitr(1, 1, 1, 1);
        bitr(0, 0, 0, 2);
        abort_row(0, 0, 2);
        idle_row(0, 2);
        // 1101101 non-overlapping: one hit
        start_row(1, 4'b1101, 3'd4, 0, 8'd0, 0, 2);
        bitr(1, 1, 0, 0); bitr(1, 1, 0, 0); bitr(1, 0, 0, 0); bitr(1, 1, 1, 0);
        bitr(1, 1, 0, 1); bitr(1, 0, 0, 1); bitr(1, 1, 0, 1);
        bitr(0, 0, 0, 1);
        abort_row(0, 0, 1);
        // 1101101 overlapping: hits on bits 4 and 7
        start_row(1, 4'b1101, 3'd4, 1, 8'd0, 0, 1);
        bitr(1, 1, 0, 0); bitr(1, 1, 0, 0); bitr(1, 0, 0, 0); bitr(1, 1, 1, 0);
        bitr(1, 1, 0, 1); bitr(1, 0, 0, 1); bitr(1, 1, 1, 1);
        bitr(0, 0, 0, 2);
        abort_row(0, 0, 2);
        // target 3: DONE after the third hit, fourth pattern ignored
        start_row(1, 4'b1101, 3'd4, 0, 8'd3, 0, 2);
        for (int k = 0; k < 3; k++) begin
            bitr(1, 1, 0, 8'(k)); bitr(1, 1, 0, 8'(k)); bitr(1, 0, 0, 8'(k)); bitr(1, 1, 1, 8'(k));
        end
        done_bit(1); done_bit(1); done_bit(0); done_bit(1);
        // in_valid gaps, then abort coincident with a hit
        start_row(1, 4'b1101, 3'd4, 0, 8'd0, 1, 3);
        bitr(1, 1, 0, 0); bitr(0, 0, 0, 0); bitr(1, 1, 0, 0); bitr(0, 1, 0, 0);
        bitr(1, 0, 0, 0); bitr(0, 1, 0, 0); bitr(1, 1, 1, 0);
        bitr(0, 0, 0, 1);
        bitr(1, 1, 0, 1); bitr(1, 1, 0, 1); bitr(1, 0, 0, 1);
        abort_row(1, 1, 1);
        idle_row(0, 1);
        // cfg_len=7 clamps to 4
        start_row(1, 4'b1101, 3'd7, 0, 8'd0, 0, 1);
        bitr(1, 1, 0, 0); bitr(1, 1, 0, 0); bitr(1, 0, 0, 0); bitr(1, 1, 1, 0);
        bitr(0, 0, 0, 1);
        // config write during RUN is held off
        row(0, 1, 4'b0000, 3'd2, 1, 8'd0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 8'd1);
        bitr(1, 1, 0, 1); bitr(1, 1, 0, 1); bitr(1, 0, 0, 1); bitr(1, 1, 1, 1);
        bitr(0, 0, 0, 2);
        abort_row(0, 0, 2);
        idle_row(0, 2);
        // cfg_len=0 clamps to 2, pattern 01
        start_row(1, 4'b0001, 3'd0, 0, 8'd0, 0, 2);
        bitr(1, 0, 0, 0); bitr(1, 1, 1, 0);
        // reset mid-run restores default config
        row(1, 0, 4'h0, 3'd0, 0, 8'd0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 8'd1);
        idle_row(0, 0);
        start_row(0, 4'h0, 3'd0, 0, 8'd0, 0, 0);
        bitr(1, 0, 0, 0); bitr(1, 1, 0, 0); bitr(1, 1, 0, 0); bitr(1, 0, 0, 0); bitr(1, 1, 1, 0);
        bitr(0, 0, 0, 1);
        abort_row(0, 0, 1);
        idle_row(0, 1);
    endtask

    initial begin
        vec_t       zero_v;
        logic [3:0] p;
        zero_v = '{default: '0};
        drive(zero_v);
`ifdef SEQDET_IRQ_EN
        irq_clr = 1'b0;
`endif
        build_table();

        foreach (vecs[i]) begin
            @(posedge clk);
            #1 drive(vecs[i]);
            #3;
            if (vecs[i].chk) begin
                check("out",       i, 8'(out),               8'(vecs[i].eo));
                check("busy",      i, 8'(busy),              8'(vecs[i].eb));
                check("done",      i, 8'(done),              8'(vecs[i].ed));
                check("cfg_ready", i, 8'(cfg_bus.cfg_ready), 8'(vecs[i].er));
                check("hit_count", i, hit_count,             vecs[i].ec);
            end
        end

        // hit_count saturation with target=0: pattern 11, len 2, overlapping -> hit on every bit after the first
        @(posedge clk);
        #1 drive(zero_v);
        cfg_bus.cfg_valid = 1; cfg_bus.cfg_pattern = 4'b0011; cfg_bus.cfg_len = 3'd2;
        cfg_bus.cfg_overlap = 1; cfg_bus.cfg_target = 8'd0; start = 1;
        @(posedge clk);
        #1 cfg_bus.cfg_valid = 0; start = 0; in_valid = 1; din = 1;
        repeat (100) @(posedge clk);
        #4 check("hit_count_mid", 1000, hit_count, 8'd99);
        repeat (200) @(posedge clk);
        #1 in_valid = 0;
        #3 check("hit_count_sat", 1001, hit_count, 8'hFF);
        check("busy_sat", 1002, 8'(busy), 8'd1);
        abort = 1;
        @(posedge clk);
        #1 abort = 0;
        #3 check("busy_abort", 1003, 8'(busy), 8'd0);
        check("hit_count_hold", 1004, hit_count, 8'hFF);

`ifdef SEQDET_IRQ_EN
        // irq sets on DONE entry, clears on irq_clr, and a coincident set wins
        p = 4'b1101;
        @(posedge clk);
        #1 cfg_bus.cfg_valid = 1; cfg_bus.cfg_pattern = 4'b1101; cfg_bus.cfg_len = 3'd4;
        cfg_bus.cfg_overlap = 0; cfg_bus.cfg_target = 8'd1; start = 1;
        @(posedge clk);
        #1 cfg_bus.cfg_valid = 0; start = 0; in_valid = 1;
        for (int k = 3; k >= 0; k--) begin
            din = p[k];
            #3 check("irq_before", 1100 + k, 8'(irq), 8'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        #3 check("irq_set", 1110, 8'(irq), 8'd1);
        check("done_irq", 1111, 8'(done), 8'd1);
        irq_clr = 1;
        @(posedge clk);
        #1 irq_clr = 0;
        #3 check("irq_clr", 1112, 8'(irq), 8'd0);
        start = 1;
        @(posedge clk);
        #1 start = 0; in_valid = 1;
        for (int k = 3; k >= 0; k--) begin
            din = p[k];
            irq_clr = (k == 0);
            @(posedge clk);
            #1;
        end
        in_valid = 0; irq_clr = 0;
        #3 check("irq_set_over_clr", 1113, 8'(irq), 8'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
